// File: rtl/roulette_pkg.sv
// Shared roulette definitions: spin-result properties word layout, bet type codes,
// payout multipliers and the settler FSM state encoding.
package roulette_pkg;

    localparam int PROPS_W    = 14;
    localparam int NUM_LSB    = 0;
    localparam int NUM_W      = 6;
    localparam int RED_BIT    = 6;
    localparam int EVEN_BIT   = 7;
    localparam int HIGH_BIT   = 8;
    localparam int DOZEN_LSB  = 9;
    localparam int COLUMN_LSB = 11;
    localparam int SEL_W      = 2;
    localparam int ZERO_BIT   = 13;

    localparam int NUM_DOUBLE_ZERO = 37;

    localparam int MULT_STRAIGHT = 35;
    localparam int MULT_DOZEN    = 2;
    localparam int MULT_EVEN     = 1;

    typedef enum logic [3:0] {
        BT_STRAIGHT = 4'd0,
        BT_RED      = 4'd1,
        BT_BLACK    = 4'd2,
        BT_EVEN     = 4'd3,
        BT_ODD      = 4'd4,
        BT_LOW      = 4'd5,
        BT_HIGH     = 4'd6,
        BT_DOZEN    = 4'd7,
        BT_COLUMN   = 4'd8
    } bet_type_e;

    // Payout select: NONE means the bet pays nothing (lost or invalid).
    typedef enum logic [1:0] {
        MULT_NONE = 2'd0,
        MULT_X1   = 2'd1,
        MULT_X2   = 2'd2,
        MULT_X35  = 2'd3
    } mult_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bet_match.sv
// Combinational judge for one bet against a latched properties word; also usable
// standalone for "would this bet win" highlighting.
module bet_match
    import roulette_pkg::*;
(
    input  logic [PROPS_W-1:0] props,
    input  logic [3:0]         bet_type,
    input  logic [5:0]         bet_value,
    output logic               win,
    output logic [1:0]         mult
);

    logic             zero;
    logic [NUM_W-1:0] number;
    logic [SEL_W-1:0] dozen;
    logic [SEL_W-1:0] column;
    logic             sel_ok;

    assign zero   = props[ZERO_BIT];
    assign number = props[NUM_LSB +: NUM_W];
    assign dozen  = props[DOZEN_LSB +: SEL_W];
    assign column = props[COLUMN_LSB +: SEL_W];
    // Dozen/column selectors must be exactly 1..3; upper bits set means invalid.
    assign sel_ok = (bet_value >= 6'd1) && (bet_value <= 6'd3);

    always_comb begin
        win  = 1'b0;
        mult = MULT_NONE;
        case (bet_type)
            BT_STRAIGHT: begin
                win  = (number == bet_value);
                mult = MULT_X35;
            end
            BT_RED:   begin win = ~zero &  props[RED_BIT];  mult = MULT_X1; end
            BT_BLACK: begin win = ~zero & ~props[RED_BIT];  mult = MULT_X1; end
            BT_EVEN:  begin win = ~zero &  props[EVEN_BIT]; mult = MULT_X1; end
            BT_ODD:   begin win = ~zero & ~props[EVEN_BIT]; mult = MULT_X1; end
            BT_LOW:   begin win = ~zero & ~props[HIGH_BIT]; mult = MULT_X1; end
            BT_HIGH:  begin win = ~zero &  props[HIGH_BIT]; mult = MULT_X1; end
            BT_DOZEN: begin
                win  = sel_ok && (dozen == bet_value[SEL_W-1:0]);
                mult = MULT_X2;
            end
            BT_COLUMN: begin
                win  = sel_ok && (column == bet_value[SEL_W-1:0]);
                mult = MULT_X2;
            end
            default: begin
                win  = 1'b0;
                mult = MULT_NONE;
            end
        endcase
        if (!win) begin
            mult = MULT_NONE;
        end
    end

endmodule

// File: rtl/bet_settler.sv
// Bet table plus settlement engine: on each spin it walks the table one bet per
// cycle, streams per-bet results and accumulates the total payout.
module bet_settler
    import roulette_pkg::*;
#(
    parameter  int MAX_BETS = 16,
    parameter  int STAKE_W  = 16,
    parameter  int TOTAL_W  = 32,
    localparam int IW       = $clog2(MAX_BETS),
    localparam int CW       = IW + 1,
    localparam int AW       = STAKE_W + 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               bet_wr_en,
    input  logic [3:0]         bet_type,
    input  logic [5:0]         bet_value,
    input  logic [STAKE_W-1:0] bet_stake,
    output logic               bet_ready,
    output logic [CW-1:0]      bet_count,
    input  logic               clear_bets,
    input  logic               props_valid,
    input  logic [31:0]        properties,
    output logic               busy,
    output logic               result_valid,
    output logic [IW-1:0]      result_idx,
    output logic               result_win,
    output logic [AW-1:0]      result_amount,
    output logic               done,
    output logic [TOTAL_W-1:0] total_payout,
    output logic [CW-1:0]      win_count
);

    logic [3:0]         tbl_type  [MAX_BETS];
    logic [5:0]         tbl_value [MAX_BETS];
    logic [STAKE_W-1:0] tbl_stake [MAX_BETS];

    state_e             state;
    state_e             state_next;
    logic [IW-1:0]      idx;
    logic [PROPS_W-1:0] props_q;
    logic [CW-1:0]      count_q;

    logic               wr_fire;
    logic               last_bet;
    logic               cur_win;
    logic [1:0]         cur_mult;
    logic [AW-1:0]      stake_ext;
    logic [AW-1:0]      cur_amount;
    logic               unused_props;

    assign unused_props = ^properties[31:PROPS_W];
    assign bet_count    = count_q;
    assign last_bet     = ({1'b0, idx} == (count_q - CW'(1)));
    // Spin and clear both take priority over a write in the same cycle.
    assign wr_fire      = bet_wr_en & bet_ready & ~props_valid & ~clear_bets;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (props_valid) begin
                    state_next = (count_q == '0) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_bet) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy      = (state != ST_IDLE);
        bet_ready = (state == ST_IDLE) && (count_q != CW'(MAX_BETS));
    end

    bet_match u_match (
        .props     (props_q),
        .bet_type  (tbl_type[idx]),
        .bet_value (tbl_value[idx]),
        .win       (cur_win),
        .mult      (cur_mult)
    );

    // Shift-add payouts: x36 = x32 + x4, x3 = x2 + x1, x2 = x1 << 1.
    assign stake_ext = AW'(tbl_stake[idx]);
    always_comb begin
        cur_amount = '0;
        case (cur_mult)
            MULT_X35: cur_amount = (stake_ext << 5) + (stake_ext << 2);
            MULT_X2:  cur_amount = (stake_ext << 1) + stake_ext;
            MULT_X1:  cur_amount = stake_ext << 1;
            default:  cur_amount = '0;
        endcase
    end

    // Table storage has no reset; only entries below count_q are ever read.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            tbl_type[count_q[IW-1:0]]  <= bet_type;
            tbl_value[count_q[IW-1:0]] <= bet_value;
            tbl_stake[count_q[IW-1:0]] <= bet_stake;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q       <= '0;
            idx           <= '0;
            props_q       <= '0;
            result_valid  <= 1'b0;
            result_idx    <= '0;
            result_win    <= 1'b0;
            result_amount <= '0;
            done          <= 1'b0;
            total_payout  <= '0;
            win_count     <= '0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (props_valid) begin
                        props_q      <= properties[PROPS_W-1:0];
                        total_payout <= '0;
                        win_count    <= '0;
                        idx          <= '0;
                    end else if (clear_bets) begin
                        count_q <= '0;
                    end else if (wr_fire) begin
                        count_q <= count_q + CW'(1);
                    end
                end
                ST_SCAN: begin
                    result_valid  <= 1'b1;
                    result_idx    <= idx;
                    result_win    <= cur_win;
                    result_amount <= cur_amount;
                    total_payout  <= total_payout + TOTAL_W'(cur_amount);
                    if (cur_win) begin
                        win_count <= win_count + CW'(1);
                    end
                    idx <= idx + IW'(1);
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bet_settler.sv
// Directed bench for bet_settler: expected results are queued at stimulus time and
// a negedge monitor pops and compares every result and done pulse.
module tb_bet_settler;

    localparam int IW = 4;
    localparam int CW = 5;
    localparam int AW = 22;

    logic          clock;
    logic          reset;
    logic          bet_wr_en;
    logic [3:0]    bet_type;
    logic [5:0]    bet_value;
    logic [15:0]   bet_stake;
    logic          bet_ready;
    logic [CW-1:0] bet_count;
    logic          clear_bets;
    logic          props_valid;
    logic [31:0]   properties;
    logic          busy;
    logic          result_valid;
    logic [IW-1:0] result_idx;
    logic          result_win;
    logic [AW-1:0] result_amount;
    logic          done;
    logic [31:0]   total_payout;
    logic [CW-1:0] win_count;

    bet_settler dut (
        .clock         (clock),
        .reset         (reset),
        .bet_wr_en     (bet_wr_en),
        .bet_type      (bet_type),
        .bet_value     (bet_value),
        .bet_stake     (bet_stake),
        .bet_ready     (bet_ready),
        .bet_count     (bet_count),
        .clear_bets    (clear_bets),
        .props_valid   (props_valid),
        .properties    (properties),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_idx    (result_idx),
        .result_win    (result_win),
        .result_amount (result_amount),
        .done          (done),
        .total_payout  (total_payout),
        .win_count     (win_count)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_expected = 0;
    int run = 0;

    // Scoreboard queues: {idx, win, amount} and {total, wins} with count/cycle
    logic [IW+AW:0] exp_q[$];
    logic [36:0]    done_q[$];
    int             done_n_q[$];
    int             done_cyc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor
    logic [IW+AW:0] e;
    logic [36:0]    d;
    int             dn;
    int             dc;
    always @(negedge clock) begin
        if (result_valid) begin
            run++;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result_idx", result_idx, e[IW+AW:AW+1]);
                chk("result_win", result_win, e[AW]);
                chk("result_amount", result_amount, e[AW-1:0]);
            end
        end else begin
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    d  = done_q.pop_front();
                    dn = done_n_q.pop_front();
                    dc = done_cyc_q.pop_front();
                    chk("total_payout", total_payout, d[36:5]);
                    chk("win_count", win_count, d[4:0]);
                    chk("result_run_len", run, dn);
                    chk("done_cycle", cyc, dc);
                end
            end
            run = 0;
        end
    end

    // Driver tasks
    task automatic push_res(input int idx, input logic win, input int amt);
        exp_q.push_back({IW'(idx), win, AW'(amt)});
    endtask

    task automatic write_bet(input int t, input int v, input int s);
        bet_type  = 4'(t);
        bet_value = 6'(v);
        bet_stake = 16'(s);
        bet_wr_en = 1'b1;
        @(posedge clock); #1;
        bet_wr_en = 1'b0;
    endtask

    task automatic clear_table();
        clear_bets = 1'b1;
        @(posedge clock); #1;
        clear_bets = 1'b0;
    endtask

    task automatic spin_start(input logic [31:0] p, input int n, input int tot, input int wins);
        properties  = p;
        props_valid = 1'b1;
        @(posedge clock); #1;
        props_valid = 1'b0;
        done_q.push_back({32'(tot), 5'(wins)});
        done_n_q.push_back(n);
        done_cyc_q.push_back(cyc + n + 1);
        done_expected++;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock); #1;
            if (done_cnt >= done_expected) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bet_ready"}, bet_ready, 1);
        chk({tag, "_bet_count"}, bet_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result_idx"}, result_idx, 0);
        chk({tag, "_result_win"}, result_win, 0);
        chk({tag, "_result_amount"}, result_amount, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_total_payout"}, total_payout, 0);
        chk({tag, "_win_count"}, win_count, 0);
    endtask

    initial begin
        reset       = 1'b1;
        bet_wr_en   = 1'b0;
        bet_type    = '0;
        bet_value   = '0;
        bet_stake   = '0;
        clear_bets  = 1'b0;
        props_valid = 1'b0;
        properties  = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Mixed bets against 7 (red, odd, low, dozen 1, column 1)
        write_bet(0, 7, 10);
        write_bet(1, 0, 5);
        write_bet(4, 0, 3);
        write_bet(7, 1, 4);
        write_bet(8, 1, 2);
        chk("count_after_5", bet_count, 5);
        push_res(0, 1, 360);
        push_res(1, 1, 10);
        push_res(2, 1, 6);
        push_res(3, 1, 12);
        push_res(4, 1, 6);
        spin_start(32'h0A47, 5, 394, 5);
        chk("busy_in_scan", busy, 1);
        chk("bet_ready_in_scan", bet_ready, 0);
        wait_done();
        chk("held_total_394", total_payout, 394);
        chk("held_wins_5", win_count, 5);
        chk("busy_after", busy, 0);

        // Zero kills outside bets; straight 0 wins
        clear_table();
        write_bet(1, 0, 10);
        write_bet(2, 0, 10);
        write_bet(3, 0, 10);
        write_bet(5, 0, 10);
        write_bet(0, 0, 1);
        for (int i = 0; i < 4; i++) push_res(i, 0, 0);
        push_res(4, 1, 36);
        spin_start(32'h2000, 5, 36, 1);
        wait_done();

        // Double zero: only straight 37 wins, retained table reused
        write_bet(0, 37, 1);
        for (int i = 0; i < 5; i++) push_res(i, 0, 0);
        push_res(5, 1, 36);
        spin_start(32'h2025, 6, 36, 1);
        wait_done();

        // Clear beats simultaneous write; empty-table spin
        bet_type   = 4'd1;
        bet_value  = 6'd0;
        bet_stake  = 16'd9;
        bet_wr_en  = 1'b1;
        clear_bets = 1'b1;
        @(posedge clock); #1;
        bet_wr_en  = 1'b0;
        clear_bets = 1'b0;
        chk("count_after_clear_wr", bet_count, 0);
        spin_start(32'h0A47, 0, 0, 0);
        wait_done();
        chk("empty_total", total_payout, 0);
        chk("empty_wins", win_count, 0);

        // Fill to capacity, 17th write dropped
        for (int i = 0; i < 16; i++) write_bet(1, 0, 1);
        chk("full_bet_ready", bet_ready, 0);
        chk("full_count", bet_count, 16);
        write_bet(1, 0, 100);
        chk("overflow_count", bet_count, 16);
        for (int i = 0; i < 16; i++) push_res(i, 1, 2);
        spin_start(32'h0A47, 16, 32, 16);
        wait_done();

        // Invalid type / selector; write during spin dropped; spin during scan ignored
        clear_table();
        write_bet(1, 0, 1);
        write_bet(12, 0, 7);
        write_bet(7, 5, 3);
        write_bet(2, 0, 2);
        chk("count_after_4", bet_count, 4);
        push_res(0, 1, 2);
        push_res(1, 0, 0);
        push_res(2, 0, 0);
        push_res(3, 0, 0);
        bet_type  = 4'd1;
        bet_value = 6'd0;
        bet_stake = 16'd9;
        bet_wr_en = 1'b1;
        spin_start(32'h0A47, 4, 2, 1);
        bet_wr_en   = 1'b0;
        properties  = 32'h2000;
        props_valid = 1'b1;
        @(posedge clock); #1;
        props_valid = 1'b0;
        wait_done();
        chk("count_after_spin_wr", bet_count, 4);

        // Reset during the third scan cycle: no done, table emptied
        push_res(0, 1, 2);
        push_res(1, 0, 0);
        properties  = 32'h0A47;
        props_valid = 1'b1;
        @(posedge clock); #1;
        props_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("leftover_results", exp_q.size(), 0);
        chk("leftover_done", done_q.size(), 0);
        chk("done_events", done_cnt, done_expected);
        chk("post_reset_count", bet_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
